// File: rtl/game_flow_fsm_if.sv
// Event inputs and HUD/state outputs of the game flow controller.
// master drives keyboard/gameplay events, slave is the controller.
interface game_flow_fsm_if #(
  parameter int TIMER_W = 8
);
  logic               frame_tick;
  logic [7:0]         Keycode;
  logic               player_hit;
  logic               level_clear;
  logic [2:0]         outstate;
  logic               game_run;
  logic [3:0]         lives;
  logic [3:0]         level;
  logic [TIMER_W-1:0] countdown;

  modport master (
    output frame_tick, Keycode, player_hit, level_clear,
    input  outstate, game_run, lives, level, countdown
  );

  modport slave (
    input  frame_tick, Keycode, player_hit, level_clear,
    output outstate, game_run, lives, level, countdown
  );
endinterface

// File: rtl/game_flow_fsm.sv
// Game flow sequencer: menu/play/pause/resume/game-over/win with lives, level and resume countdown.
// One-cycle event latency, all outputs registered; no backpressure, events are single-cycle pulses or key edges.
module game_flow_fsm #(
  parameter logic [7:0] START_KEY     = 8'd44,
  parameter logic [7:0] PAUSE_KEY     = 8'd41,
  parameter int         NUM_LIVES     = 3,
  parameter int         NUM_LEVELS    = 4,
  parameter int         RESUME_FRAMES = 60,
  parameter int         TIMER_W       = 8
) (
  input logic Clock,
  input logic Reset,
  game_flow_fsm_if.slave gf
);

  typedef enum logic [2:0] {
    MENU      = 3'b000,
    PLAY      = 3'b001,
    PAUSE     = 3'b010,
    RESUME    = 3'b011,
    GAME_OVER = 3'b100,
    WIN       = 3'b101
  } state_t;

  localparam logic [3:0]         LIVES_INIT = 4'(NUM_LIVES);
  localparam logic [3:0]         LAST_LEVEL = 4'(NUM_LEVELS);
  localparam logic [TIMER_W-1:0] CD_INIT    = TIMER_W'(RESUME_FRAMES);
  localparam logic [TIMER_W-1:0] CD_ONE     = TIMER_W'(1);
  // With no countdown configured, "resuming" lands straight back in PLAY.
  localparam state_t             RESUME_ENTRY = (RESUME_FRAMES > 0) ? RESUME : PLAY;

  state_t             state_q, state_d;
  logic [3:0]         lives_q, lives_d;
  logic [3:0]         level_q, level_d;
  logic [TIMER_W-1:0] cd_q, cd_d;
  logic [7:0]         prev_key_q;
  logic               run_q;

  logic start_press;
  logic pause_press;
  logic any_press;

  assign start_press = (gf.Keycode == START_KEY) && (prev_key_q != START_KEY);
  assign pause_press = (gf.Keycode == PAUSE_KEY) && (prev_key_q != PAUSE_KEY);
  assign any_press   = (gf.Keycode != 8'd0) && (gf.Keycode != prev_key_q);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= MENU;
      lives_q    <= 4'd0;
      level_q    <= 4'd0;
      cd_q       <= '0;
      prev_key_q <= 8'd0;
      run_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      lives_q    <= lives_d;
      level_q    <= level_d;
      cd_q       <= cd_d;
      prev_key_q <= gf.Keycode;
      run_q      <= (state_d == PLAY);
    end
  end

  always_comb begin
    state_d = state_q;
    lives_d = lives_q;
    level_d = level_q;
    cd_d    = cd_q;

    case (state_q)
      MENU: begin
        if (start_press) begin
          state_d = PLAY;
          lives_d = LIVES_INIT;
          level_d = 4'd1;
          cd_d    = '0;
        end
      end

      PLAY: begin
        // Priority: hit, then level clear, then pause; losers are dropped.
        if (gf.player_hit) begin
          if (lives_q == 4'd1) begin
            state_d = GAME_OVER;
            lives_d = 4'd0;
          end else begin
            lives_d = lives_q - 4'd1;
            state_d = RESUME_ENTRY;
            cd_d    = CD_INIT;
          end
        end else if (gf.level_clear) begin
          if (level_q == LAST_LEVEL) begin
            state_d = WIN;
          end else begin
            level_d = level_q + 4'd1;
            state_d = RESUME_ENTRY;
            cd_d    = CD_INIT;
          end
        end else if (pause_press) begin
          state_d = PAUSE;
        end
      end

      PAUSE: begin
        if (any_press) begin
          state_d = RESUME_ENTRY;
          cd_d    = CD_INIT;
        end
      end

      RESUME: begin
        if (pause_press) begin
          state_d = PAUSE;
        end else if (gf.frame_tick) begin
          if (cd_q == CD_ONE) begin
            state_d = PLAY;
            cd_d    = '0;
          end else begin
            cd_d = cd_q - CD_ONE;
          end
        end
      end

      GAME_OVER, WIN: begin
        if (start_press) begin
          state_d = MENU;
        end
      end

      default: begin
        state_d = MENU;
      end
    endcase
  end

  assign gf.outstate  = state_q;
  assign gf.game_run  = run_q;
  assign gf.lives     = lives_q;
  assign gf.level     = level_q;
  assign gf.countdown = cd_q;

endmodule

// File: tb/tb_game_flow_fsm.sv
// Drives two controllers (60-frame and zero-frame resume) with directed then random events,
// comparing every cycle against a rule-level model of the game flow.
module tb_game_flow_fsm;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  game_flow_fsm_if #(.TIMER_W(8)) ifa ();
  game_flow_fsm_if #(.TIMER_W(8)) ifb ();

  game_flow_fsm #(.RESUME_FRAMES(60), .TIMER_W(8)) dut_a (
    .Clock (clk),
    .Reset (rst),
    .gf    (ifa)
  );

  game_flow_fsm #(.RESUME_FRAMES(0), .TIMER_W(8)) dut_b (
    .Clock (clk),
    .Reset (rst),
    .gf    (ifb)
  );

  // st uses the published outstate codes: 0 menu,1 play,2 pause,3 resume,4 over,5 win
  typedef struct packed {
    int st;
    int lv;
    int lvl;
    int cd;
    int pk;
  } mdl_t;

  mdl_t ma = '0;
  mdl_t mb = '0;
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input int exp);
    n_tests++;
    if (got !== 32'(exp)) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic mdl_t mstep(input mdl_t m, input int rf, input bit r,
                                 input int key, input bit ft, input bit hit, input bit clr);
    mdl_t n;
    bit go, esc, anyk, to_resume;
    n = m;
    go   = (key == 44) && (m.pk != 44);
    esc  = (key == 41) && (m.pk != 41);
    anyk = (key != 0) && (key != m.pk);
    n.pk = key;
    to_resume = 1'b0;
    if (r) return '0;
    if (m.st == 0 && go) begin
      n.st = 1; n.lv = 3; n.lvl = 1; n.cd = 0;
    end else if (m.st == 1) begin
      if (hit) begin
        if (m.lv == 1) begin n.st = 4; n.lv = 0; end
        else begin n.lv = m.lv - 1; to_resume = 1'b1; end
      end else if (clr) begin
        if (m.lvl == 4) n.st = 5;
        else begin n.lvl = m.lvl + 1; to_resume = 1'b1; end
      end else if (esc) begin
        n.st = 2;
      end
    end else if (m.st == 2 && anyk) begin
      to_resume = 1'b1;
    end else if (m.st == 3) begin
      if (esc) n.st = 2;
      else if (ft) begin
        n.cd = m.cd - 1;
        if (n.cd == 0) n.st = 1;
      end
    end else if ((m.st == 4 || m.st == 5) && go) begin
      n.st = 0;
    end
    if (to_resume) begin
      n.cd = rf;
      n.st = (rf > 0) ? 3 : 1;
    end
    return n;
  endfunction

  task automatic cmp(input string p, input mdl_t m, input logic [2:0] os, input logic gr,
                     input logic [3:0] lv, input logic [3:0] lvl, input logic [7:0] cd);
    chk({p, "_outstate"}, 32'(os), m.st);
    chk({p, "_game_run"}, 32'(gr), (m.st == 1) ? 1 : 0);
    chk({p, "_lives"}, 32'(lv), m.lv);
    chk({p, "_level"}, 32'(lvl), m.lvl);
    chk({p, "_countdown"}, 32'(cd), m.cd);
  endtask

  task automatic cyc(input int key, input bit ft, input bit hit, input bit clr, input bit r);
    ifa.Keycode = 8'(key); ifa.frame_tick = ft; ifa.player_hit = hit; ifa.level_clear = clr;
    ifb.Keycode = 8'(key); ifb.frame_tick = ft; ifb.player_hit = hit; ifb.level_clear = clr;
    rst = r;
    @(posedge clk);
    ma = mstep(ma, 60, r, key, ft, hit, clr);
    mb = mstep(mb, 0, r, key, ft, hit, clr);
    #1;
    cmp("a", ma, ifa.outstate, ifa.game_run, ifa.lives, ifa.level, ifa.countdown);
    cmp("b", mb, ifb.outstate, ifb.game_run, ifb.lives, ifb.level, ifb.countdown);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int key;
    bit r;
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    chk("reset_outstate", ifa.outstate, 0);
    chk("reset_run", ifa.game_run, 0);
    chk("reset_lives", ifa.lives, 0);
    chk("reset_level", ifa.level, 0);

    // start, then held start key does nothing more
    cyc(44, 0, 0, 0, 0);
    chk("start_state", ifa.outstate, 1);
    chk("start_run", ifa.game_run, 1);
    chk("start_lives", ifa.lives, 3);
    chk("start_level", ifa.level, 1);
    for (int i = 0; i < 10; i++) cyc(44, 0, 0, 0, 0);
    chk("held_start", ifa.outstate, 1);

    // pause, held esc ignored, release, new key resumes; tick in entry cycle ignored
    cyc(41, 0, 0, 0, 0);
    chk("pause_state", ifa.outstate, 2);
    cyc(41, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("pause_held", ifa.outstate, 2);
    cyc(4, 1, 0, 0, 0);
    chk("resume_state", ifa.outstate, 3);
    chk("resume_cd", ifa.countdown, 60);
    ticks(59);
    chk("cd_59_state", ifa.outstate, 3);
    chk("cd_59_count", ifa.countdown, 1);
    ticks(1);
    chk("cd_done_state", ifa.outstate, 1);
    chk("cd_done_count", ifa.countdown, 0);

    // lives run out
    cyc(0, 0, 1, 0, 0);
    chk("hit1_lives", ifa.lives, 2);
    chk("hit1_state", ifa.outstate, 3);
    chk("rf0_hit_state", ifb.outstate, 1);
    chk("rf0_hit_lives", ifb.lives, 2);
    ticks(60);
    cyc(0, 0, 1, 0, 0);
    chk("hit2_lives", ifa.lives, 1);
    ticks(60);
    cyc(0, 0, 1, 0, 0);
    chk("over_state", ifa.outstate, 4);
    chk("over_lives", ifa.lives, 0);
    cyc(44, 0, 0, 0, 0);
    chk("over_to_menu", ifa.outstate, 0);

    // levels to win; hits ignored in WIN
    cyc(0, 0, 0, 0, 0);
    cyc(44, 0, 0, 0, 0);
    for (int l = 2; l <= 4; l++) begin
      cyc(0, 0, 0, 1, 0);
      chk("clr_level", ifa.level, l);
      ticks(60);
    end
    cyc(0, 0, 0, 1, 0);
    chk("win_state", ifa.outstate, 5);
    chk("win_level", ifa.level, 4);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);
    chk("win_hit_state", ifa.outstate, 5);
    chk("win_hit_lives", ifa.lives, 3);

    // simultaneous events: hit wins; pause beats tick
    cyc(44, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(44, 0, 0, 0, 0);
    cyc(41, 0, 1, 1, 0);
    chk("prio_lives", ifa.lives, 2);
    chk("prio_state", ifa.outstate, 3);
    chk("prio_level", ifa.level, 1);
    cyc(0, 0, 0, 0, 0);
    ticks(10);
    cyc(41, 1, 0, 0, 0);
    chk("pause_vs_tick_state", ifa.outstate, 2);
    chk("pause_vs_tick_cd", ifa.countdown, 50);

    // reset mid-countdown
    cyc(0, 0, 0, 0, 0);
    cyc(5, 0, 0, 0, 0);
    chk("reload_cd", ifa.countdown, 60);
    ticks(30);
    chk("mid_cd", ifa.countdown, 30);
    cyc(0, 0, 0, 0, 1);
    chk("midrst_state", ifa.outstate, 0);
    chk("midrst_cd", ifa.countdown, 0);
    chk("midrst_lives", ifa.lives, 0);
    chk("midrst_level", ifa.level, 0);

    // random traffic
    key = 0;
    for (int i = 0; i < 5000; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        case ($urandom_range(0, 5))
          0, 1:    key = 0;
          2:       key = 41;
          3:       key = 44;
          4:       key = 4;
          default: key = int'($urandom_range(1, 255));
        endcase
      end
      r = ($urandom_range(0, 799) == 0) || (i == 0);
      cyc(key, $urandom_range(0, 2) == 0, $urandom_range(0, 39) == 0,
          $urandom_range(0, 39) == 0, r);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
